imm_pack: RTL and testbench
===========================

Name: imm_pack

Overview:
- Inverse of the core's immediate extender. Takes an instruction-format selector, a 32-bit immediate value and the non-immediate instruction bits.
- Produces the packed instr[31:7] field with the immediate scattered into its architectural bit positions, and flags values the selected format cannot represent.
- Sits in the instruction-generation / program-loader path feeding instruction memory. Streaming valid/ready interface, 2-entry output buffer.

Parameters:
- CNT_W, 16, width of saturating range-error counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- ImmSrc  in  3  format: 000 I/load, 001 S, 010 B, 011 J, 100 U, 101 shamt
- ImmVal  in  32  immediate value (signed for I/S/B/J; raw for U/shamt)
- Base  in  25  instr[31:7] with immediate positions don't-care (rd/rs1/rs2/funct bits)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- Imm  out  25  packed instr[31:7]
- RangeErr  out  1  ImmVal not representable in ImmSrc format, or ImmSrc illegal
- ErrCount  out  CNT_W  saturating count of accepted beats with RangeErr=1

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, Imm=0, RangeErr=0, ErrCount=0.
  - Buffer emptied.
  - Reset has priority over any concurrent transfer; in-flight beats are discarded.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: beat accepted at edge N is presented on Imm/RangeErr with out_valid=1 after edge N (1 cycle), provided the buffer was empty.
- Buffer:
  - 2-entry FIFO of {Imm, RangeErr}.
  - in_ready = not full; registered, no combinational path from out_ready.
  - Simultaneous push and pop when full is not allowed, since in_ready=0.
  - Simultaneous push and pop at 1 entry leaves occupancy at 1.
  - Strict FIFO order. Output is stable while out_valid && !out_ready.
- Packing, with V=ImmVal and Imm[i] corresponding to instr[i+7]. Bits not listed are taken from Base.
  - 000: Imm[24:13]=V[11:0]. Err if V[31:11] not all equal.
  - 001: Imm[24:18]=V[11:5], Imm[4:0]=V[4:0]. Err if V[31:11] not all equal.
  - 010: Imm[24]=V[12], Imm[23:18]=V[10:5], Imm[4:1]=V[4:1], Imm[0]=V[11]. Err if V[31:12] not all equal or V[0]=1.
  - 011: Imm[24]=V[20], Imm[23:14]=V[10:1], Imm[13]=V[11], Imm[12:5]=V[19:12]. Err if V[31:20] not all equal or V[0]=1.
  - 100: Imm[24:5]=V[31:12]. Err if V[11:0]!=0.
  - 101: Imm[17:13]=V[4:0]; Imm[24:18] taken from Base (funct7). Err if V[31:5]!=0.
  - 110/111: Imm=Base, Err=1.
- On error the truncated bits are still packed as above. The beat is never dropped.
- ErrCount increments on input acceptance of an erroring beat and saturates at all-ones.
- Round-trip invariant: if RangeErr=0, feeding Imm and the matching selector to the extender returns V, except shamt, which returns V[4:0] zero-extended.

Decomposition:
- Shared package holds:
  - ImmSrc encodings (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SH), shared with the extender and the control decoder.
  - The instruction-field width constant (25).
- Natural sub-module: imm_pack_fifo, a 2-entry synchronous FIFO with registered full/empty. Packing and range check stay combinational in the top level, ahead of the FIFO push.

Test Plan:
- I-type, Base=0: V=0xFFFFF800 -> Imm=0x1000000, Err=0. V=0x00000800 -> Err=1, ErrCount=1.
- B-type, Base=0: V=0x00000FFE -> Imm=0x0FC001F, Err=0. V=0x00001000 -> Err=1. V=0x00000003 -> Err=1 (misaligned).
- U-type, Base=0x000001F (rd=x31 at Imm[4:0]): V=0x12345000 -> Imm=0x02468BF, Err=0. V=0x12345001 -> Err=1.
- Backpressure: out_ready=0, push beats A,B,C on consecutive cycles -> in_ready=0 after B, C held at input. Raise out_ready -> A,B,C emerge in order, one per cycle.
- Reset mid-operation: 2 beats buffered and ErrCount=5, reset low for one edge -> out_valid=0, in_ready=1, ErrCount=0. The first beat after reset appears 1 cycle after acceptance.
- Saturation/random round-trip: force ErrCount to 0xFFFF plus one more error -> stays 0xFFFF. Then 10k random (ImmSrc, V) beats -> every Err=0 beat decodes back through the extender model to V, and every Err=1 beat matches the range rules.

Source files
------------

// File: rtl/imm_pack_pkg.sv
// Shared definitions for immediate packing: format selectors, field widths and the
// buffered beat payload.
package imm_pack_pkg;

    localparam int unsigned INSTR_W   = 25;
    localparam int unsigned IMM_SRC_W = 3;
    localparam int unsigned VAL_W     = 32;
    localparam int unsigned BEAT_W    = INSTR_W + 1;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_U  = 3'b100,
        IMM_SH = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [INSTR_W-1:0] imm;
        logic               err;
    } pack_beat_t;

    // True when v[31:lsb] are all equal, i.e. v survives sign-extension from bit lsb.
    function automatic logic hi_uniform(input logic [VAL_W-1:0] v, input int unsigned lsb);
        logic [VAL_W-1:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_pack_fifo.sv
// Two-entry synchronous FIFO with head/tail registers; head is presented directly,
// and full/empty are registered so ready has no path from pop.
module imm_pack_fifo #(
    parameter int unsigned W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic         do_push, do_pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        do_push = push && ready_q;
        do_pop  = pop && valid_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is 1 here; the new beat replaces the departing head.
                if (cnt_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
        valid_d = (cnt_d != 2'd0);
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign head_data = head_q;
    assign valid     = valid_q;
    assign ready     = ready_q;

endmodule

// File: rtl/imm_pack.sv
// Scatters an immediate into its instr[31:7] bit positions for the selected format,
// flags unrepresentable values, and buffers results in a 2-entry FIFO.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ImmSrc,
    input  logic [31:0]        ImmVal,
    input  logic [INSTR_W-1:0] Base,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] Imm,
    output logic               RangeErr,
    output logic [CNT_W-1:0]   ErrCount
);

    pack_beat_t       pack_c;
    pack_beat_t       head_beat;
    logic             accept;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Field scatter and range check; truncated bits are packed even on error.
    always_comb begin
        pack_c.imm = Base;
        pack_c.err = 1'b0;
        case (ImmSrc)
            IMM_I: begin
                pack_c.imm[24:13] = ImmVal[11:0];
                pack_c.err        = !hi_uniform(ImmVal, 11);
            end
            IMM_S: begin
                pack_c.imm[24:18] = ImmVal[11:5];
                pack_c.imm[4:0]   = ImmVal[4:0];
                pack_c.err        = !hi_uniform(ImmVal, 11);
            end
            IMM_B: begin
                pack_c.imm[24]    = ImmVal[12];
                pack_c.imm[23:18] = ImmVal[10:5];
                pack_c.imm[4:1]   = ImmVal[4:1];
                pack_c.imm[0]     = ImmVal[11];
                pack_c.err        = !hi_uniform(ImmVal, 12) || ImmVal[0];
            end
            IMM_J: begin
                pack_c.imm[24]    = ImmVal[20];
                pack_c.imm[23:14] = ImmVal[10:1];
                pack_c.imm[13]    = ImmVal[11];
                pack_c.imm[12:5]  = ImmVal[19:12];
                pack_c.err        = !hi_uniform(ImmVal, 20) || ImmVal[0];
            end
            IMM_U: begin
                pack_c.imm[24:5] = ImmVal[31:12];
                pack_c.err       = (ImmVal[11:0] != 12'd0);
            end
            IMM_SH: begin
                pack_c.imm[17:13] = ImmVal[4:0];
                pack_c.err        = (ImmVal[31:5] != 27'd0);
            end
            default: begin
                pack_c.err = 1'b1;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && pack_c.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    imm_pack_fifo #(
        .W (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (in_valid),
        .push_data (pack_c),
        .pop       (out_ready),
        .head_data (head_beat),
        .valid     (out_valid),
        .ready     (in_ready)
    );

    assign Imm      = head_beat.imm;
    assign RangeErr = head_beat.err;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: instruction-level encoding/decoding model with a queue
// scoreboard, directed literal vectors, backpressure, reset, saturation and random beats.
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ImmSrc;
    logic [31:0] ImmVal;
    logic [24:0] Base;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] Imm;
    logic        RangeErr;
    logic [15:0] ErrCount;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    imm_pack #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .ImmVal    (ImmVal),
        .Base      (Base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Imm       (Imm),
        .RangeErr  (RangeErr),
        .ErrCount  (ErrCount)
    );

    typedef struct {
        logic [2:0]  src;
        logic [31:0] v;
        logic [24:0] imm;
        logic        err;
    } exp_t;

    exp_t        mq[$];
    int unsigned mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encode as an assembler would: build the full 32-bit instruction word.
    function automatic logic [24:0] model_imm(input logic [2:0] s, input logic [31:0] v,
                                              input logic [24:0] b);
        logic [31:0] ins;
        ins = {b, 7'b0};
        case (s)
            3'd0: ins[31:20] = v[11:0];
            3'd1: begin ins[31:25] = v[11:5]; ins[11:7] = v[4:0]; end
            3'd2: begin
                ins[31] = v[12]; ins[30:25] = v[10:5]; ins[11:8] = v[4:1]; ins[7] = v[11];
            end
            3'd3: begin
                ins[31] = v[20]; ins[30:21] = v[10:1]; ins[20] = v[11]; ins[19:12] = v[19:12];
            end
            3'd4: ins[31:12] = v[31:12];
            3'd5: ins[24:20] = v[4:0];
            default: ;
        endcase
        return ins[31:7];
    endfunction

    function automatic logic model_err(input logic [2:0] s, input logic [31:0] v);
        int sv;
        sv = $signed(v);
        case (s)
            3'd0, 3'd1: return (sv < -2048) || (sv > 2047);
            3'd2: return (sv < -4096) || (sv > 4095) || v[0];
            3'd3: return (sv < -1048576) || (sv > 1048575) || v[0];
            3'd4: return (v % 32'd4096) != 32'd0;
            3'd5: return v > 32'd31;
            default: return 1'b1;
        endcase
    endfunction

    // Reference immediate extender operating on the instruction word.
    function automatic logic [31:0] extend(input logic [2:0] s, input logic [24:0] f);
        logic [31:0] ins;
        ins = {f, 7'b0};
        case (s)
            3'd0: return {{20{ins[31]}}, ins[31:20]};
            3'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: return {ins[31:12], 12'b0};
            default: return {27'b0, ins[24:20]};
        endcase
    endfunction

    bit   m_pop, m_push;
    exp_t m_e;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() < 2);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                m_e.src = ImmSrc;
                m_e.v   = ImmVal;
                m_e.imm = model_imm(ImmSrc, ImmVal, Base);
                m_e.err = model_err(ImmSrc, ImmVal);
                mq.push_back(m_e);
                if (m_e.err && mcnt != 32'hFFFF) mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("ErrCount", 32'(ErrCount), mcnt);
            if (mq.size() != 0) begin
                check("Imm", 32'(Imm), 32'(mq[0].imm));
                check("RangeErr", 32'(RangeErr), 32'(mq[0].err));
                if (out_ready && !RangeErr) begin
                    check("roundtrip", extend(mq[0].src, Imm),
                          (mq[0].src == 3'd5) ? {27'b0, mq[0].v[4:0]} : mq[0].v);
                end
            end
        end
    end

    // Single beat into an empty buffer; checks 1-cycle latency and literal result.
    task automatic beat(input string name, input logic [2:0] s, input logic [31:0] v,
                        input logic [24:0] b, input logic [24:0] ei, input logic ee);
        @(posedge clk); #1;
        ImmSrc = s; ImmVal = v; Base = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_imm"}, 32'(Imm), 32'(ei));
        check({name, "_err"}, 32'(RangeErr), 32'(ee));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_100_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        int  cyc;
        bit  acc;
        bit  need_new;
        int  mode;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ImmSrc = 3'd0; ImmVal = 32'd0; Base = 25'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imm", 32'(Imm), 32'd0);
        check("rst_err", 32'(RangeErr), 32'd0);
        check("rst_cnt", 32'(ErrCount), 32'd0);

        beat("i_min",   3'd0, 32'hFFFFF800, 25'h0, 25'h1000000, 1'b0);
        beat("i_over",  3'd0, 32'h00000800, 25'h0, 25'h1000000, 1'b1);
        check("cnt_after_i", 32'(ErrCount), 32'd1);
        beat("s_neg1",  3'd1, 32'hFFFFFFFF, 25'h0, 25'h1FC001F, 1'b0);
        beat("b_max",   3'd2, 32'h00000FFE, 25'h0, 25'h0FC001F, 1'b0);
        beat("b_over",  3'd2, 32'h00001000, 25'h0, 25'h1000000, 1'b1);
        beat("b_odd",   3'd2, 32'h00000003, 25'h0, 25'h0000002, 1'b1);
        beat("j_max",   3'd3, 32'h000FFFFE, 25'h0, 25'h0FFFFE0, 1'b0);
        beat("u_ok",    3'd4, 32'h12345000, 25'h000001F, 25'h02468BF, 1'b0);
        beat("u_low",   3'd4, 32'h12345001, 25'h000001F, 25'h02468BF, 1'b1);
        beat("sh_ok",   3'd5, 32'h00000005, 25'h1000000, 25'h100A000, 1'b0);
        beat("sh_over", 3'd5, 32'h00000020, 25'h1000000, 25'h1000000, 1'b1);
        check("cnt_directed", 32'(ErrCount), 32'd5);

        // Backpressure: A,B fill the buffer, C waits at the input.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; ImmSrc = 3'd0; Base = 25'h0; ImmVal = 32'd1;
        @(posedge clk); #1;
        ImmVal = 32'd2;
        @(posedge clk); #1;
        ImmVal = 32'd3;
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_head_a", 32'(Imm), 32'h2000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_head_b", 32'(Imm), 32'h4000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_head_c", 32'(Imm), 32'h6000);
        @(posedge clk); #1;
        check("bp_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with two beats buffered.
        in_valid = 1'b1; ImmVal = 32'd7;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        check("pre_rst_cnt", 32'(ErrCount), 32'd5);
        pulse_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cnt", 32'(ErrCount), 32'd0);
        beat("post_rst_ill", 3'd6, 32'd0, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1);
        check("cnt_ill", 32'(ErrCount), 32'd1);

        // Saturation: stream error beats at one per cycle.
        pulse_reset();
        ImmSrc = 3'd0; ImmVal = 32'h800; Base = 25'h0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1 check("sat_reach", 32'(ErrCount), 32'hFFFF);
        @(posedge clk); #1;
        check("sat_hold", 32'(ErrCount), 32'hFFFF);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random beats with random backpressure.
        sent = 0; cyc = 0; need_new = 1'b1;
        while (sent < 10000 && cyc < 40000) begin
            if (need_new) begin
                ImmSrc = 3'($urandom_range(0, 7));
                Base   = 25'($urandom);
                mode   = $urandom_range(0, 3);
                case (mode)
                    0: ImmVal = $urandom;
                    1: ImmVal = 32'($signed(13'($urandom)));
                    2: ImmVal = 32'($urandom_range(0, 40));
                    default: ImmVal = $urandom & 32'hFFFFF000;
                endcase
                need_new = 1'b0;
            end
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                need_new = 1'b1;
            end
        end
        check("rand_budget", 32'(sent), 32'd10000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("rand_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
